// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the CPU controller's
// MAR/MDR memory port and mem_responder.
//   rd, wr     : read / write request levels (controller -> memory)
//   addr       : word address from the MAR
//   wdata      : write data from the MDR
//   rdata      : registered read data (memory -> controller)
//   mem_ready  : one-cycle completion pulse
//   mem_busy   : a request is in flight
//   mem_err    : out-of-range access flag, only when MEM_BOUNDS_CHECK_EN is defined
// Modports: master = controller side, slave = memory side.
interface mem_responder_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 8
);
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata;
  logic              mem_ready;
  logic              mem_busy;
`ifdef MEM_BOUNDS_CHECK_EN
  logic              mem_err;

  modport master (output rd, wr, addr, wdata,
                  input  rdata, mem_ready, mem_busy, mem_err);
  modport slave  (input  rd, wr, addr, wdata,
                  output rdata, mem_ready, mem_busy, mem_err);
`else
  modport master (output rd, wr, addr, wdata,
                  input  rdata, mem_ready, mem_busy);
  modport slave  (input  rd, wr, addr, wdata,
                  output rdata, mem_ready, mem_busy);
`endif
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory that answers the controller's fetch,
// load and store handshake. A request sampled in IDLE is latched, held for
// WAIT_CYCLES wait states, then performed in ACCESS, which raises mem_ready
// for exactly one cycle.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset (array contents are kept)
//   bus    : mem_responder_if.slave (rd, wr, addr, wdata, rdata, mem_ready,
//            mem_busy, and mem_err when MEM_BOUNDS_CHECK_EN is defined)
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag addresses >= DEPTH
// (write suppressed, read returns 0, mem_err pulses with mem_ready).
// Without it the address wraps modulo DEPTH.
module mem_responder #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              op_wr_q, op_wr_d;
  logic              ready_q, ready_d;
  logic              mem_we;
  logic [IDX_W-1:0]  idx;

  logic [WIDTH-1:0]  mem [DEPTH];

  // Modulo on the full address keeps every address bit in use; for a
  // power-of-two DEPTH this reduces to the low IDX_W bits.
  assign idx = IDX_W'(32'(addr_q) % DEPTH);

`ifdef MEM_BOUNDS_CHECK_EN
  logic err_q, err_d;
  logic oob;
  assign oob         = (32'(addr_q) >= DEPTH);
  assign bus.mem_err = err_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    mem_we  = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.rd || bus.wr) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          op_wr_d = bus.wr;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACCESS;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
`ifdef MEM_BOUNDS_CHECK_EN
        if (oob) begin
          err_d = 1'b1;
          if (!op_wr_q) rdata_d = '0;
        end else
`endif
        if (op_wr_q) mem_we  = 1'b1;
        else         rdata_d = mem[idx];
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
`ifdef MEM_BOUNDS_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Storage is not reset; a reset landing on the ACCESS edge aborts the write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[idx] <= wdata_q;
  end

  assign bus.rdata     = rdata_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DEPTH       = 128;
  localparam int unsigned WAIT_CYCLES = 1;
  localparam int          LAT         = 2 + WAIT_CYCLES;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  mem_responder #(
    .WIDTH(WIDTH),
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected array contents and the last value rdata holds.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rdata;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_apply(input logic r, input logic w, input logic [7:0] a,
                             input logic [31:0] d,
                             output logic [31:0] exp_rd, output logic exp_err);
    int unsigned ai;
    bit          oob;
    ai  = a;
    oob = BOUNDS && (ai >= DEPTH);
    ai  = ai % DEPTH;
    if (w) begin
      if (!oob) ref_mem[ai] = d;
    end else if (r) begin
      ref_rdata = oob ? 32'h0 : ref_mem[ai];
    end
    exp_rd  = ref_rdata;
    exp_err = oob;
  endtask

  task automatic do_access(input logic r, input logic w, input logic [7:0] a,
                           input logic [31:0] d,
                           output logic [31:0] got_rd, output int lat,
                           output logic busy_ok);
    @(negedge clk);
    bus.rd    = r;
    bus.wr    = w;
    bus.addr  = a;
    bus.wdata = d;
    lat     = 0;
    busy_ok = 1'b1;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.mem_ready === 1'b1) break;
      if (bus.mem_busy !== 1'b1) busy_ok = 1'b0;
      if (lat >= 40) break;
    end
    if (bus.mem_ready === 1'b1 && bus.mem_busy !== 1'b0) busy_ok = 1'b0;
    got_rd = bus.rdata;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
  endtask

  task automatic run_and_check(input string name, input logic r, input logic w,
                               input logic [7:0] a, input logic [31:0] d,
                               input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] got;
    int          lat;
    logic        bok;
    string       tag;
    tag = $sformatf("%s@%h(err_exp=%0d)", name, a, exp_err);
    do_access(r, w, a, d, got, lat, bok);
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_busy"}, {31'h0, bok}, 32'h1);
    check({tag, "_rdata"}, got, exp_rd);
`ifdef MEM_BOUNDS_CHECK_EN
    check({tag, "_err"}, {31'h0, bus.mem_err}, {31'h0, exp_err});
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] erd;
    logic        eerr;
    logic        r, w;
    logic [7:0]  a;
    logic [31:0] d;

    // Reset then idle
    reset = 1'b1;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    ref_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_ready", {31'h0, bus.mem_ready}, 32'h0);
    check("reset_busy", {31'h0, bus.mem_busy}, 32'h0);
`ifdef MEM_BOUNDS_CHECK_EN
    check("reset_err", {31'h0, bus.mem_err}, 32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("idle_ready", {31'h0, bus.mem_ready}, 32'h0);
    end

    // Fill every word with a known value so later reads are predictable.
    for (int i = 0; i < int'(DEPTH); i++) begin
      d = $urandom;
      model_apply(1'b0, 1'b1, 8'(i), d, erd, eerr);
      run_and_check("prefill", 1'b0, 1'b1, 8'(i), d, erd, eerr);
    end

    // Directed vectors with hand-derived expectations
    tbl[0] = '{1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 8'h20, 32'h12345678, 32'hDEADBEEF, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 8'h20, 32'h0,        32'h12345678, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 32'h0BADF00D, 32'h12345678, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'h80, 32'hFFFFFFFF, 32'h12345678, BOUNDS};
    tbl[6] = '{1'b1, 1'b0, 8'h00, 32'h0, BOUNDS ? 32'h0BADF00D : 32'hFFFFFFFF, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 8'h80, 32'h0, BOUNDS ? 32'h0 : 32'hFFFFFFFF, BOUNDS};
    for (int i = 0; i < 8; i++) begin
      model_apply(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, erd, eerr);
      run_and_check($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr,
                    tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err);
    end

    // Held read request: a pulse every LAT cycles, never two in a row
    @(negedge clk);
    bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = 8'h10;
    model_apply(1'b1, 1'b0, 8'h10, 32'h0, erd, eerr);
    for (int c = 1; c <= 4 * LAT; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("held_ready_c%0d", c), {31'h0, bus.mem_ready},
            {31'h0, (c % LAT) == 0});
      if ((c % LAT) == 0) check("held_rdata", bus.rdata, erd);
    end
    bus.rd = 1'b0;

    // Reset during WAIT aborts the write and suppresses mem_ready
    model_apply(1'b0, 1'b1, 8'h30, 32'h11223344, erd, eerr);
    run_and_check("pre_abort_wr", 1'b0, 1'b1, 8'h30, 32'h11223344, erd, eerr);
    @(negedge clk);
    bus.wr = 1'b1; bus.addr = 8'h30; bus.wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    check("abort_busy_before", {31'h0, bus.mem_busy}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    bus.wr = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready", {31'h0, bus.mem_ready}, 32'h0);
    check("abort_busy", {31'h0, bus.mem_busy}, 32'h0);
    check("abort_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    ref_rdata = 32'h0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check("abort_no_ready", {31'h0, bus.mem_ready}, 32'h0);
    end
    model_apply(1'b1, 1'b0, 8'h30, 32'h0, erd, eerr);
    run_and_check("abort_readback", 1'b1, 1'b0, 8'h30, 32'h0, 32'h11223344, 1'b0);

    // Random traffic against the model, including out-of-range addresses
    for (int i = 0; i < 60; i++) begin
      r = 1'($urandom_range(0, 1));
      w = r ? 1'($urandom_range(0, 1)) : 1'b1;
      a = 8'($urandom_range(0, 255));
      d = $urandom;
      model_apply(r, w, a, d, erd, eerr);
      run_and_check("rand", r, w, a, d, erd, eerr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
